multi_and_reduce_pipe: RTL and testbench
========================================

// Module: multi_and_reduce_pipe
// PURPOSE
//  Parametrised, pipelined N-input logic reduction built from PNU_AND4 cells.
//  Computes AND, NAND, OR or NOR of WIDTH bits; the operation is selectable per transaction.
//  Uses a 4-ary tree with one register level per tree level and valid/ready flow control.
//  Feeds decode/flag logic that needs wide reductions at clock rate.
// PARAMETERS
//  WIDTH   16   reduction input width; legal range 1..256
//  STAGES  derived, not overridable: max(1, ceil(log4(WIDTH))); equals pipeline latency
//  PADW    derived: 4**STAGES; the tree input width after padding
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous active-low reset; deassertion is synchronised externally
//  in_valid   in   1      in_data/in_op are valid
//  in_ready   out  1      block accepts the input this cycle
//  in_data    in   WIDTH  operand bits
//  in_op      in   2      00 AND, 01 NAND, 10 NOR, 11 OR
//  out_valid  out  1      out holds a result
//  out_ready  in   1      consumer accepts the result
//  out        out  1      reduction result
//  out_op     out  2      in_op echoed with the result
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valid bits, data registers and op registers clear to 0.
//    Outputs: out_valid=0, out=0, out_op=0; in_ready=1 once rst_n is high.
//  - Operation encoding: inv_in = in_op[1], inv_out = in_op[0].
//    Result = inv_out ^ AND(x), where x = in_data ^ {WIDTH{inv_in}}.
//    Hence NOR = AND(~d) and OR = ~AND(~d).
//  - Padding: x is padded from WIDTH to PADW bits with 1s after inversion (the AND identity).
//    Pad bits never affect the result.
//  - Stage k (0..STAGES-1): a combinational level of PNU_AND4 cells followed by a register.
//    PADW/4^(k+1) cells in stage k; the op propagates alongside the data.
//  - Output: out = inv_out ^ final-stage bit. This inversion is combinational from the registers;
//    there is no extra cycle.
//  - Latency: exactly STAGES cycles from input acceptance to out_valid with no stall.
//    WIDTH=16 gives a latency of 2.
//  - Throughput: one transaction per cycle when out_ready=1.
//  - Handshake:
//    - Transfers occur on valid&&ready.
//    - out and out_op are held stable while out_valid=1 and out_ready=0.
//    - in_valid may be asserted independent of in_ready; the producer must hold its data
//      until accepted.
//  - Bubble collapse:
//    - ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready.
//    - in_ready = ready_0, which is combinational through the stages from out_ready.
//    - An empty stage always accepts data, even while downstream stages stall.
//  - Full pipe: all STAGES registers valid and out_ready=0 gives in_ready=0; no data is lost
//    or duplicated.
//  - Simultaneous events: an output pop and an input push in the same cycle both complete
//    when the pipe is full.
//  - Ordering: results leave strictly in acceptance order.
//  - Reset mid-operation: all in-flight transactions are discarded and no result is emitted
//    for them.
//  - WIDTH=1: STAGES=1, and the single cell sees {3'b111, x}.
// STRUCTURE
//  - Shared package/header multi_and_pkg:
//    - OP_AND/OP_NAND/OP_NOR/OP_OR constants.
//    - clog4() function used to derive STAGES.
//  - Sub-module and_reduce_stage #(IN_W):
//    - IN_W/4 PNU_AND4 instances, plus the data/op/valid register and the stage ready logic.
//    - Instantiated STAGES times in a generate loop.
//  - Top level: input inversion and padding, the stage chain, and output inversion.
// TESTING
//  1. Assert rst_n=0 -> out_valid=0, out=0, out_op=0; after release in_ready=1.
//  2. WIDTH=16, AND: 0xFFFF -> out=1; 0xFFFE -> out=0. out_valid rises exactly 2 cycles
//     after acceptance.
//  3. WIDTH=16, ops 00/01/10/11:
//     - OR: 0x0000 -> 0; 0x0100 -> 1.
//     - NOR: 0x0000 -> 1.
//     - NAND: 0xFFFF -> 0.
//     - out_op echoes each op.
//  4. Stream 8 back-to-back random words with out_ready=1 -> 8 results on consecutive cycles,
//     in order, each matching the reference model.
//  5. Stream with out_ready=0 for 6 cycles -> in_ready drops after 2 accepted (pipe full).
//     out is stable throughout; on out_ready=1 all results drain in order, with no loss and
//     no duplicates.
//  6. WIDTH=5: AND 5'h1F -> 1, OR 5'h00 -> 0 (padding is inert). Pulse rst_n low with 2
//     transactions in flight -> out_valid=0 immediately, and no stale result follows.

Source files
------------

// File: rtl/multi_and_pkg.sv
// Shared constants and elaboration helpers for the pipelined AND-tree reduction.
package multi_and_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_NOR  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    // Number of 4-ary levels needed to cover n inputs (0 for n <= 1).
    function automatic int clog4(input int n);
        int s;
        int p;
        s = 0;
        p = 1;
        for (int i = 0; i < 16; i++) begin
            if (p < n) begin
                p = p * 4;
                s = s + 1;
            end
        end
        return s;
    endfunction

    // Bit offset of tree level k inside the flattened level vector.
    function automatic int lvl_off(input int padw, input int k);
        int o;
        o = 0;
        for (int j = 0; j < 16; j++) begin
            if (j < k) o = o + (padw >> (2 * j));
        end
        return o;
    endfunction

endpackage

// File: rtl/and_reduce_stage.sv
// One tree level: IN_W/4 AND4 cells feeding a registered, flow-controlled stage.
module and_reduce_stage
    import multi_and_pkg::*;
#(
    parameter int IN_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [IN_W-1:0]     in_data_i,
    input  logic [1:0]          in_op_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [IN_W/4-1:0]   out_data_o,
    output logic [1:0]          out_op_o
);
    localparam int OUT_W = IN_W / 4;

    logic [OUT_W-1:0] red_d;
    logic [OUT_W-1:0] data_q;
    logic [1:0]       op_q;
    logic             valid_q;

    for (genvar i = 0; i < OUT_W; i++) begin : g_cell
        PNU_AND4 u_and4 (
            .a_i (in_data_i[4*i +: 4]),
            .y_o (red_d[i])
        );
    end

    // An empty register always accepts, so bubbles collapse under a stall.
    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= red_d;
                op_q   <= in_op_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_op_o    = op_q;

endmodule

// File: rtl/pnu_and4.sv
// Four-input AND leaf cell used to build the reduction tree.
module PNU_AND4 (
    input  logic [3:0] a_i,
    output logic       y_o
);
    assign y_o = &a_i;
endmodule

// File: rtl/multi_and_reduce_pipe.sv
// Pipelined AND/NAND/OR/NOR reduction of WIDTH bits with valid/ready flow control.
module multi_and_reduce_pipe
    import multi_and_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out,
    output logic [1:0]       out_op
);
    localparam int STAGES = (clog4(WIDTH) < 1) ? 1 : clog4(WIDTH);
    localparam int PADW   = 4 ** STAGES;
    localparam int TOTW   = lvl_off(PADW, STAGES + 1);

    logic [PADW-1:0]        padded;
    logic [TOTW-1:0]        lvl;
    logic [STAGES:0]        vld_pipe;
    logic [STAGES:0][1:0]   op_pipe;

    // NOR/OR invert the operand first; pad with 1s so extra tree inputs are inert.
    always_comb begin
        padded              = '1;
        padded[WIDTH-1:0]   = in_data ^ {WIDTH{in_op[1]}};
    end

    assign lvl[PADW-1:0] = padded;
    assign vld_pipe[0]   = in_valid;
    assign op_pipe[0]    = in_op;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W  = PADW >> (2 * k);
        localparam int I_OFF = lvl_off(PADW, k);
        localparam int O_OFF = lvl_off(PADW, k + 1);

        logic rdy_up;
        logic rdy_dn;

        // Ready chains through per-stage nets so it stays purely combinational.
        if (k == STAGES - 1) begin : g_last
            assign rdy_dn = out_ready;
        end else begin : g_mid
            assign rdy_dn = g_stage[k+1].rdy_up;
        end

        and_reduce_stage #(.IN_W(IN_W)) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .in_valid_i  (vld_pipe[k]),
            .in_ready_o  (rdy_up),
            .in_data_i   (lvl[I_OFF +: IN_W]),
            .in_op_i     (op_pipe[k]),
            .out_valid_o (vld_pipe[k+1]),
            .out_ready_i (rdy_dn),
            .out_data_o  (lvl[O_OFF +: IN_W/4]),
            .out_op_o    (op_pipe[k+1])
        );
    end

    assign in_ready  = g_stage[0].rdy_up;
    assign out_valid = vld_pipe[STAGES];
    assign out_op    = op_pipe[STAGES];
    assign out       = op_pipe[STAGES][0] ^ lvl[TOTW-1];

endmodule

// File: tb/tb_multi_and_reduce_pipe.sv
// Scoreboard bench for multi_and_reduce_pipe: WIDTH=16 and WIDTH=5 instances.
module tb_multi_and_reduce_pipe;
    import multi_and_pkg::*;

    localparam int LAT = 2;

    typedef struct {
        logic       exp;
        logic [1:0] op;
        int         acc;
        bit         lat;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1, out16;
    logic [15:0] in_data16 = '0;
    logic [1:0]  in_op16 = '0, out_op16;
    logic        in_valid5 = 1'b0, in_ready5, out_valid5, out_ready5 = 1'b1, out5;
    logic [4:0]  in_data5 = '0;
    logic [1:0]  in_op5 = '0, out_op5;

    ent_t q16[$];
    ent_t q5[$];

    logic       hold_v = 1'b0;
    logic       hold_o;
    logic [1:0] hold_op;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_and_reduce_pipe #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_data(in_data16), .in_op(in_op16), .out_valid(out_valid16),
        .out_ready(out_ready16), .out(out16), .out_op(out_op16)
    );

    multi_and_reduce_pipe #(.WIDTH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_data(in_data5), .in_op(in_op5), .out_valid(out_valid5),
        .out_ready(out_ready5), .out(out5), .out_op(out_op5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic send16(input logic [15:0] d, input logic [1:0] op, input logic e, input bit lat);
        bit ok;
        ent_t en;
        ok = 1'b0;
        in_valid16 = 1'b1;
        in_data16  = d;
        in_op16    = op;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready16) begin
                en.exp = e; en.op = op; en.acc = cyc; en.lat = lat;
                q16.push_back(en);
                ok = 1'b1;
            end
        end
        if (!ok) chk("accept16_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1 in_valid16 = 1'b0;
    endtask

    task automatic send5(input logic [4:0] d, input logic [1:0] op, input logic e, input bit lat);
        bit ok;
        ent_t en;
        ok = 1'b0;
        in_valid5 = 1'b1;
        in_data5  = d;
        in_op5    = op;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (in_ready5) begin
                en.exp = e; en.op = op; en.acc = cyc; en.lat = lat;
                q5.push_back(en);
                ok = 1'b1;
            end
        end
        if (!ok) chk("accept5_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1 in_valid5 = 1'b0;
    endtask

    // Monitor: pops on each output handshake; also checks the held value under stall.
    always @(negedge clk) begin
        ent_t en;
        if (rst_n && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                chk("unexpected16", 32'(out_valid16), 32'd0);
            end else begin
                en = q16.pop_front();
                chk("out16", 32'(out16), 32'(en.exp));
                chk("out_op16", 32'(out_op16), 32'(en.op));
                if (en.lat) chk("latency16", 32'(cyc - en.acc), 32'(LAT));
            end
        end
        if (rst_n && out_valid16 && !out_ready16) begin
            if (hold_v) chk("hold16", {30'd0, out16, out_op16} , {30'd0, hold_o, hold_op});
            hold_v  = 1'b1;
            hold_o  = out16;
            hold_op = out_op16;
        end else begin
            hold_v = 1'b0;
        end
        if (rst_n && out_valid5 && out_ready5) begin
            if (q5.size() == 0) begin
                chk("unexpected5", 32'(out_valid5), 32'd0);
            end else begin
                en = q5.pop_front();
                chk("out5", 32'(out5), 32'(en.exp));
                chk("out_op5", 32'(out_op5), 32'(en.op));
                if (en.lat) chk("latency5", 32'(cyc - en.acc), 32'(LAT));
            end
        end
    end

    initial begin
        // Reset state
        #3;
        chk("rst_out_valid16", 32'(out_valid16), 32'd0);
        chk("rst_out16", 32'(out16), 32'd0);
        chk("rst_out_op16", 32'(out_op16), 32'd0);
        chk("rst_out_valid5", 32'(out_valid5), 32'd0);
        chk("rst_out5", 32'(out5), 32'd0);
        chk("rst_out_op5", 32'(out_op5), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready16_after_rst", 32'(in_ready16), 32'd1);
        chk("in_ready5_after_rst", 32'(in_ready5), 32'd1);
        @(posedge clk);
        #1;

        // Isolated transactions, latency checked from an idle pipe
        send16(16'hFFFF, OP_AND,  1'b1, 1'b1); repeat (3) @(posedge clk); #1;
        send16(16'hFFFE, OP_AND,  1'b0, 1'b1); repeat (3) @(posedge clk); #1;
        send16(16'h0000, OP_OR,   1'b0, 1'b1); repeat (3) @(posedge clk); #1;
        send16(16'h0100, OP_OR,   1'b1, 1'b1); repeat (3) @(posedge clk); #1;
        send16(16'h0000, OP_NOR,  1'b1, 1'b1); repeat (3) @(posedge clk); #1;
        send16(16'hFFFF, OP_NAND, 1'b0, 1'b1); repeat (3) @(posedge clk); #1;

        // Back-to-back stream, full throughput
        send16(16'hFFFF, OP_AND,  1'b1, 1'b1);
        send16(16'h7FFF, OP_AND,  1'b0, 1'b1);
        send16(16'hFFFF, OP_NAND, 1'b0, 1'b1);
        send16(16'h1234, OP_NAND, 1'b1, 1'b1);
        send16(16'h0000, OP_NOR,  1'b1, 1'b1);
        send16(16'h8000, OP_NOR,  1'b0, 1'b1);
        send16(16'h0000, OP_OR,   1'b0, 1'b1);
        send16(16'h0001, OP_OR,   1'b1, 1'b1);
        repeat (4) @(posedge clk); #1;

        // Stall: pipe fills after two, output held, then drains in order
        out_ready16 = 1'b0;
        fork
            begin
                send16(16'hA5A5, OP_AND,  1'b0, 1'b0);
                send16(16'hFFFF, OP_OR,   1'b1, 1'b0);
                send16(16'h0000, OP_NAND, 1'b1, 1'b0);
                send16(16'hFFFF, OP_NOR,  1'b0, 1'b0);
            end
        join_none
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("stall_accepted", 32'(q16.size()), 32'd2);
        chk("stall_in_ready", 32'(in_ready16), 32'd0);
        @(posedge clk);
        #1 out_ready16 = 1'b1;
        wait fork;
        repeat (4) @(posedge clk); #1;

        // WIDTH=5: padding must not affect results
        send5(5'h1F, OP_AND, 1'b1, 1'b1);
        send5(5'h00, OP_OR,  1'b0, 1'b1);
        send5(5'h1E, OP_AND, 1'b0, 1'b1);
        send5(5'h00, OP_NOR, 1'b1, 1'b1);
        repeat (4) @(posedge clk); #1;

        // Reset with two transactions in flight: both are discarded
        send5(5'h1F, OP_AND, 1'b1, 1'b1);
        send5(5'h1F, OP_OR,  1'b1, 1'b1);
        rst_n = 1'b0;
        q5.delete();
        #1;
        chk("midrst_out_valid5", 32'(out_valid5), 32'd0);
        chk("midrst_out5", 32'(out5), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;
        send5(5'h1F, OP_NAND, 1'b0, 1'b1);

        for (int t = 0; t < 50 && (q16.size() + q5.size()) != 0; t++) @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 32'(q16.size() + q5.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
